handshake_fifo_bridge: RTL
==========================

Name: handshake_fifo_bridge

Overview:
Parametrised successor to the single-entry valid/ready handshake block. Replaces its IDLE/SENDING/WAIT_ACK sequence with a DEPTH-entry buffered valid/ready bridge that sustains one transfer per clock. Adds occupancy, almost-full and transfer-count status. Sits between any producer and consumer using the team's valid/ready convention, and decouples their stall patterns.

Parameters:
DATA_W, 8, payload width in bits (>=1)
DEPTH, 4, buffer entries; power of two, >=2
AFULL_TH, 3, almost_full asserts when count >= AFULL_TH (1..DEPTH)
CNT_W, 16, width of the transfer counter

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  producer has data
s_data  in  DATA_W  producer payload
s_ready  out  1  bridge can accept; push = s_valid && s_ready
m_valid  out  1  bridge holds data for consumer
m_data  out  DATA_W  head-of-buffer payload
m_ready  in  1  consumer accepts; pop = m_valid && m_ready
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
almost_full  out  1  count >= AFULL_TH
xfer_count  out  CNT_W  number of pops since reset

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset (asserted at any time, including mid-transfer): wr_ptr, rd_ptr, count and xfer_count go to 0 immediately. m_valid=0, m_data=0, s_ready=0 while rst is high, almost_full=0. Buffered data is discarded. Storage array is not reset.
- After rst deasserts: s_ready=1 from the first rising edge onward, when count=0.
- Storage: circular buffer of DEPTH entries with log2(DEPTH)-bit pointers that wrap naturally from DEPTH-1 to 0. Occupancy is tracked by count, not by pointer comparison.
- s_ready = !rst && (count != DEPTH). Derived combinationally from registered count; it does not depend on m_ready, so no ready-to-ready combinational path exists.
- m_valid = (count != 0). m_data = mem[rd_ptr] when m_valid=1, else 0.
- Latency: data pushed at edge N appears on m_valid/m_data after edge N, i.e. first visible in cycle N+1. There is no same-cycle fall-through.
- Push only: write mem[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1, xfer_count+1.
- Push and pop in the same cycle (possible only when 0<count<DEPTH): both pointers advance, count is unchanged, xfer_count+1.
- Full (count=DEPTH): s_ready=0. A push attempt (s_valid=1) is ignored and data must not be corrupted. A pop in the same cycle frees a slot, but s_ready rises only in the next cycle.
- Empty (count=0): m_valid=0. m_ready is ignored.
- Producer-side rule: s_data must be held stable while s_valid=1 && s_ready=0. The bridge samples s_data only on push.
- Consumer-side guarantee: once m_valid=1, m_valid and m_data stay stable until pop.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- almost_full is combinational from count.
- Throughput: with s_valid=1 and m_ready=1 continuously, one transfer per clock in steady state.
- No internal FSM beyond the pointer/count datapath. Illegal states are unreachable because count is saturated by the s_ready/m_valid gating.

Test Plan:
- Reset then idle: rst high 3 cycles, then low -> during reset s_ready=0, m_valid=0, count=0; first cycle after release s_ready=1, m_valid=0.
- Single transfer: push 0xA5 at edge N with m_ready=0 -> cycle N+1: m_valid=1, m_data=0xA5, count=1. Assert m_ready one cycle -> count=0, xfer_count=1.
- Fill and block (DEPTH=4): push 0x11,0x22,0x33,0x44 with m_ready=0 -> count=4, s_ready=0, almost_full=1 from count=3. Hold s_valid=1 with 0x55 for 3 cycles -> count stays 4. Drain -> outputs 0x11,0x22,0x33,0x44 in order. Then 0x55 is accepted once s_ready returns.
- Streaming and wrap: 20 back-to-back values 0x00..0x13 with s_valid=1 and m_ready=1 -> output order matches, one pop per cycle after the first, count never exceeds 1, pointers wrap 5 times, xfer_count=20.
- Full with simultaneous pop: at count=4 assert m_ready=1 and s_valid=1 -> in that cycle no push, count becomes 3. Next cycle s_ready=1, push and pop together, count stays 3.
- Reset mid-stream: at count=2 with a push pending, assert rst asynchronously between edges -> m_valid, count and xfer_count drop to 0 without waiting for a clock edge. After release the old data never appears on m_data.

Source files
------------

// File: rtl/handshake_fifo_bridge.sv
// handshake_fifo_bridge: DEPTH-entry valid/ready buffer with occupancy, almost-full and transfer-count status
module handshake_fifo_bridge #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3,
  parameter int CNT_W    = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_s_ready,
  output logic              o_m_valid,
  output logic [DATA_W-1:0] o_m_data,
  input  logic              i_m_ready,
  output logic [CW-1:0]     o_count,
  output logic              o_almost_full,
  output logic [CNT_W-1:0]  o_xfer_count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CNT_W-1:0]  r_xfer;
  logic              w_push, w_pop;
  // handshake qualifiers and status, all from registered occupancy so ready never depends on m_ready
  always_comb begin
    o_s_ready     = !rst && (r_count != CW'(DEPTH));
    o_m_valid     = r_count != '0;
    o_m_data      = o_m_valid ? r_mem[r_rd_ptr] : '0;
    o_count       = r_count;
    o_almost_full = r_count >= CW'(AFULL_TH);
    o_xfer_count  = r_xfer;
    w_push        = i_s_valid && o_s_ready;
    w_pop         = o_m_valid && i_m_ready;
  end
  // storage is deliberately unreset; stale entries are unreachable once count is cleared
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_s_data;
  end
  // pointers wrap naturally at DEPTH (power of two); count tracks occupancy independently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_xfer   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_pop) r_xfer <= r_xfer + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule
